pipe_adder: RTL and testbench

Parametrised, pipelined integer adder/subtractor for the datapath. It replaces single-cycle combinational adds where a wide carry chain limits clock frequency. The carry chain is split into SEGS segments, one per pipeline stage, with a valid/ready handshake on both sides. It returns sum, carry-out, signed overflow and zero flags, and sustains one operation per cycle.

---
 rtl/pipe_adder_pkg.sv | 24 ++
 rtl/adder_seg.sv | 27 ++
 rtl/pipe_adder.sv | 123 ++++++++++++
 tb/tb_pipe_adder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared datapath constants for the pipelined adder.
//   PA_WIDTH / PA_SEGS : default operand width and number of carry segments.
//   pa_stage_t         : stage-record layout at the default width
//                        {valid, op1_rem, op2_rem, sum_done, carry}.
//   pa_seg_w()         : segment width helper (WIDTH / SEGS).
package pipe_adder_pkg;

  localparam int unsigned PA_WIDTH = 32;
  localparam int unsigned PA_SEGS  = 4;

  typedef struct packed {
    logic                valid;
    logic [PA_WIDTH-1:0] op1_rem;
    logic [PA_WIDTH-1:0] op2_rem;
    logic [PA_WIDTH-1:0] sum_done;
    logic                carry;
  } pa_stage_t;

  function automatic int unsigned pa_seg_w(input int unsigned width,
                                           input int unsigned segs);
    return width / segs;
  endfunction

endpackage

// File: rtl/adder_seg.sv
// adder_seg: combinational SW-bit ripple segment of the pipelined adder.
//   a, b  : segment operand bits (b already inverted for subtract)
//   cin   : carry into the segment LSB
//   s     : segment sum
//   cout  : carry out of the segment MSB
//   cmsb  : carry into the segment MSB (signed-overflow detection)
module adder_seg #(
  parameter int unsigned SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] s,
  output logic          cout,
  output logic          cmsb
);

  logic [SW:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
  assign s    = full[SW-1:0];
  assign cout = full[SW];
  // The MSB sum bit is a^b^carry_in, so the carry into it is recovered by
  // XOR-ing the sum bit back out.
  assign cmsb = a[SW-1] ^ b[SW-1] ^ s[SW-1];

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined WIDTH-bit adder/subtractor, carry chain split into
// SEGS segments, one per pipeline stage (skewed pipeline).
//   i_clk, i_rst_n       : clock (rising edge), async active-low reset
//   i_valid / o_ready    : upstream handshake; capture on i_valid && o_ready
//   i_op1, i_op2         : operands
//   i_sub, i_cin         : 0 -> op1+op2+cin, 1 -> op1-op2 (cin ignored)
//   o_valid / i_ready    : downstream handshake
//   o_sum, o_cout        : result mod 2^WIDTH, carry out (1 = no borrow on sub)
//   o_ovf, o_zero        : signed overflow, o_sum == 0
// Stall is global: every stage advances when the output slot is empty or
// being consumed, so bubbles stay in place and are never squeezed out.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH = PA_WIDTH,
  parameter int unsigned SEGS  = PA_SEGS
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  input  logic             i_sub,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int unsigned SW = pa_seg_w(WIDTH, SEGS);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] op1_rem;
    logic [WIDTH-1:0] op2_rem;
    logic [WIDTH-1:0] sum_done;
    logic             carry;
  } stage_t;

  logic             advance;
  logic [WIDTH-1:0] op2_eff;
  logic             cin_eff;
  logic             ovf_q;

  assign advance = !o_valid || i_ready;
  assign o_ready = advance;

  // Subtract is op1 + ~op2 + 1, so the inversion and forced carry happen
  // once at the input and every segment is a plain adder.
  assign op2_eff = i_sub ? ~i_op2 : i_op2;
  assign cin_eff = i_sub | i_cin;

  for (genvar k = 0; k < SEGS; k++) begin : g_seg
    stage_t        prev;
    stage_t        nxt;
    stage_t        q;
    logic [SW-1:0] s;
    logic          cout;
    logic          cmsb;

    // ---- stage k input: raw operands for k==0, stage k-1 register otherwise
    if (k == 0) begin : g_src
      always_comb begin
        prev          = '0;
        prev.valid    = i_valid;
        prev.op1_rem  = i_op1;
        prev.op2_rem  = op2_eff;
        prev.carry    = cin_eff;
      end
    end else begin : g_src
      assign prev = g_seg[k-1].q;
    end

    adder_seg #(.SW(SW)) u_seg (
      .a    (prev.op1_rem[k*SW +: SW]),
      .b    (prev.op2_rem[k*SW +: SW]),
      .cin  (prev.carry),
      .s    (s),
      .cout (cout),
      .cmsb (cmsb)
    );

    always_comb begin
      nxt                       = prev;
      nxt.sum_done[k*SW +: SW]  = s;
      nxt.carry                 = cout;
    end

    // ---- stage k register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)     q <= '0;
      else if (advance) q <= nxt;
    end

    if (k == SEGS - 1) begin : g_last
      // Operand bits are fully consumed by the final stage; they are folded
      // here only so that they are visibly accounted for.
      logic ops_unused;
      assign ops_unused = ^{q.op1_rem, q.op2_rem};

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     ovf_q <= 1'b0;
        else if (advance) ovf_q <= cout ^ cmsb;
      end
    end else begin : g_mid
      // Carry into an inner segment MSB carries no meaning for overflow.
      logic cmsb_unused;
      assign cmsb_unused = cmsb;
    end
  end

  // ---- output stage: last register drives the result port directly
  assign o_valid = g_seg[SEGS-1].q.valid;
  assign o_sum   = g_seg[SEGS-1].q.sum_done;
  assign o_cout  = g_seg[SEGS-1].q.carry;
  assign o_ovf   = ovf_q;
  assign o_zero  = (o_sum == '0);

endmodule

// File: tb/tb_pipe_adder.sv
module tb_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  // DUT A: WIDTH=32, SEGS=4
  logic        a_vin = 0, a_rdy, a_sub = 0, a_cin = 0, a_vout, a_rin = 1;
  logic        a_cout, a_ovf, a_zero;
  logic [31:0] a_op1 = '0, a_op2 = '0, a_sum;
  // DUT B: WIDTH=8, SEGS=1
  logic        b_vin = 0, b_rdy, b_sub = 0, b_cin = 0, b_vout, b_rin = 1;
  logic        b_cout, b_ovf, b_zero;
  logic [7:0]  b_op1 = '0, b_op2 = '0, b_sum;
  // DUT C: WIDTH=64, SEGS=8
  logic        c_vin = 0, c_rdy, c_sub = 0, c_cin = 0, c_vout, c_rin = 1;
  logic        c_cout, c_ovf, c_zero;
  logic [63:0] c_op1 = '0, c_op2 = '0, c_sum;

  int errors = 0;
  int checks = 0;

  pipe_adder #(.WIDTH(32), .SEGS(4)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_vin), .o_ready(a_rdy),
    .i_op1(a_op1), .i_op2(a_op2), .i_sub(a_sub), .i_cin(a_cin),
    .o_valid(a_vout), .i_ready(a_rin), .o_sum(a_sum), .o_cout(a_cout),
    .o_ovf(a_ovf), .o_zero(a_zero)
  );

  pipe_adder #(.WIDTH(8), .SEGS(1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_vin), .o_ready(b_rdy),
    .i_op1(b_op1), .i_op2(b_op2), .i_sub(b_sub), .i_cin(b_cin),
    .o_valid(b_vout), .i_ready(b_rin), .o_sum(b_sum), .o_cout(b_cout),
    .o_ovf(b_ovf), .o_zero(b_zero)
  );

  pipe_adder #(.WIDTH(64), .SEGS(8)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(c_vin), .o_ready(c_rdy),
    .i_op1(c_op1), .i_op2(c_op2), .i_sub(c_sub), .i_cin(c_cin),
    .o_valid(c_vout), .i_ready(c_rin), .o_sum(c_sum), .o_cout(c_cout),
    .o_ovf(c_ovf), .o_zero(c_zero)
  );

  // Directed vectors for the 32-bit instance, expected values by hand.
  localparam logic [31:0] V_OP1 [6] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005,
                                        32'h8000_0000, 32'h1234_5678, 32'h0000_000A};
  localparam logic [31:0] V_OP2 [6] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0007,
                                        32'h0000_0001, 32'h0000_FFFF, 32'h0000_0003};
  localparam bit          V_SUB [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam bit          V_CIN [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [31:0] V_SUM [6] = '{32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFE,
                                        32'h7FFF_FFFF, 32'h1235_5678, 32'h0000_0007};
  localparam bit          V_CO  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam bit          V_OV  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam bit          V_ZR  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: w-bit add/sub; overflow from operand/result sign bits.
  function automatic void ref_add(input int w, input logic [63:0] x, input logic [63:0] y,
                                  input logic sub, input logic cin,
                                  output logic [63:0] s, output logic co, output logic ov);
    logic [63:0] mask;
    logic [63:0] ye;
    logic [64:0] f;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    ye   = (sub ? ~y : y) & mask;
    f    = {1'b0, x & mask} + {1'b0, ye} + {64'd0, sub | cin};
    s    = f[63:0] & mask;
    co   = f[w];
    ov   = (x[w-1] == ye[w-1]) && (s[w-1] != x[w-1]);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (a_vout !== 1'b0)      begin errors++; $display("FAIL rst_valid got %b want 0", a_vout); end
    checks++; if (a_sum !== 32'd0)      begin errors++; $display("FAIL rst_sum got %h want 0", a_sum); end
    checks++; if (a_zero !== 1'b1)      begin errors++; $display("FAIL rst_zero got %b want 1", a_zero); end
    checks++; if ({a_cout, a_ovf} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b want 00", {a_cout, a_ovf}); end
    checks++; if ({b_vout, c_vout} !== 2'b00) begin errors++; $display("FAIL rst_valid_bc got %b want 00", {b_vout, c_vout}); end
    rst_n = 1'b1;
    step();
    checks++; if (a_rdy !== 1'b1)       begin errors++; $display("FAIL rst_ready got %b want 1", a_rdy); end
  endtask

  task automatic test_directed();
    for (int i = 0; i < 6; i++) begin
      a_vin = 1'b1; a_op1 = V_OP1[i]; a_op2 = V_OP2[i]; a_sub = V_SUB[i]; a_cin = V_CIN[i];
      step();
      a_vin = 1'b0;
      step();
      step();
      checks++; if (a_vout !== 1'b0) begin errors++; $display("FAIL dir%0d early_valid got %b want 0", i, a_vout); end
      step();
      checks++; if (a_vout !== 1'b1)     begin errors++; $display("FAIL dir%0d valid got %b want 1", i, a_vout); end
      checks++; if (a_sum !== V_SUM[i])  begin errors++; $display("FAIL dir%0d sum got %h want %h", i, a_sum, V_SUM[i]); end
      checks++; if (a_cout !== V_CO[i])  begin errors++; $display("FAIL dir%0d cout got %b want %b", i, a_cout, V_CO[i]); end
      checks++; if (a_ovf !== V_OV[i])   begin errors++; $display("FAIL dir%0d ovf got %b want %b", i, a_ovf, V_OV[i]); end
      checks++; if (a_zero !== V_ZR[i])  begin errors++; $display("FAIL dir%0d zero got %b want %b", i, a_zero, V_ZR[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int outn;
    outn = 0;
    a_vin = 1'b0; a_rin = 1'b1; a_sub = 1'b0; a_cin = 1'b0;
    repeat (4) step();
    for (int c = 0; c < 20; c++) begin
      if (c < 8) begin
        a_vin = 1'b1; a_op1 = 32'(c + 1); a_op2 = 32'((c + 1) << 8);
      end else begin
        a_vin = 1'b0;
      end
      step();
      if (a_vout === 1'b1) begin
        checks++; if (a_sum !== 32'(32'h101 * (outn + 1))) begin errors++; $display("FAIL b2b_data%0d got %h want %h", outn, a_sum, 32'(32'h101 * (outn + 1))); end
        checks++; if (c != outn + 3) begin errors++; $display("FAIL b2b_slot%0d got cycle %0d want %0d", outn, c, outn + 3); end
        outn++;
      end
    end
    checks++; if (outn != 8) begin errors++; $display("FAIL b2b_count got %0d want 8", outn); end
  endtask

  task automatic test_stall();
    int inn, outn;
    bit acc, ret;
    inn = 0; outn = 0;
    a_vin = 1'b0; a_rin = 1'b1;
    repeat (4) step();
    for (int c = 0; c < 40 && outn < 8; c++) begin
      a_rin = !(c >= 5 && c <= 7);
      a_vin = (inn < 8);
      a_op1 = 32'(inn + 1); a_op2 = 32'((inn + 1) << 8);
      #1;
      if (a_vout === 1'b1 && a_rin == 1'b0) begin
        checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL stall_ready got %b want 0", a_rdy); end
      end
      if (a_vout === 1'b1) begin
        checks++; if (a_sum !== 32'(32'h101 * (outn + 1))) begin errors++; $display("FAIL stall_data%0d got %h want %h", outn, a_sum, 32'(32'h101 * (outn + 1))); end
      end
      acc = a_vin && (a_rdy === 1'b1);
      ret = (a_vout === 1'b1) && a_rin;
      step();
      if (acc) inn++;
      if (ret) outn++;
    end
    a_vin = 1'b0; a_rin = 1'b1;
    checks++; if (outn != 8) begin errors++; $display("FAIL stall_count got %0d want 8", outn); end
    checks++; if (inn != 8)  begin errors++; $display("FAIL stall_accepted got %0d want 8", inn); end
  endtask

  task automatic test_reset_inflight();
    bit seen;
    a_vin = 1'b0; a_rin = 1'b1; a_sub = 1'b0; a_cin = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 3; i++) begin
      a_vin = 1'b1; a_op1 = 32'h1111_0000; a_op2 = 32'(i + 1);
      step();
    end
    a_vin = 1'b0;
    step();
    checks++; if (a_vout !== 1'b1) begin errors++; $display("FAIL inflight_pre got %b want 1", a_vout); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_vout !== 1'b0) begin errors++; $display("FAIL async_valid got %b want 0", a_vout); end
    checks++; if (a_sum !== 32'd0) begin errors++; $display("FAIL async_sum got %h want 0", a_sum); end
    checks++; if (a_zero !== 1'b1) begin errors++; $display("FAIL async_zero got %b want 1", a_zero); end
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (a_vout !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL flushed_results got valid want none"); end
    checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b want 1", a_rdy); end
  endtask

  task automatic test_w8();
    logic [63:0] es;
    logic        eco, eov;
    for (int i = 0; i < 15; i++) begin
      case (i)
        0:       begin b_op1 = 8'hFF; b_op2 = 8'h01; b_sub = 1'b0; b_cin = 1'b0; end
        1:       begin b_op1 = 8'h7F; b_op2 = 8'h01; b_sub = 1'b0; b_cin = 1'b0; end
        2:       begin b_op1 = 8'h05; b_op2 = 8'h07; b_sub = 1'b1; b_cin = 1'b0; end
        3:       begin b_op1 = 8'h80; b_op2 = 8'h01; b_sub = 1'b1; b_cin = 1'b1; end
        default: begin
          b_op1 = 8'($urandom); b_op2 = 8'($urandom);
          b_sub = 1'($urandom); b_cin = 1'($urandom);
        end
      endcase
      ref_add(8, {56'd0, b_op1}, {56'd0, b_op2}, b_sub, b_cin, es, eco, eov);
      b_vin = 1'b1;
      step();
      b_vin = 1'b0;
      checks++;
      if ({b_vout, b_cout, b_ovf, b_zero, b_sum} !== {1'b1, eco, eov, (es[7:0] == 8'd0), es[7:0]}) begin
        errors++;
        $display("FAIL w8_%0d got v%b c%b o%b z%b %h want v1 c%b o%b z%b %h",
                 i, b_vout, b_cout, b_ovf, b_zero, b_sum, eco, eov, (es[7:0] == 8'd0), es[7:0]);
      end
    end
  endtask

  task automatic test_w64();
    logic [63:0] es;
    logic        eco, eov;
    for (int i = 0; i < 12; i++) begin
      case (i)
        0:       begin c_op1 = '1; c_op2 = 64'd1; c_sub = 1'b0; c_cin = 1'b0; end
        1:       begin c_op1 = 64'h8000_0000_0000_0000; c_op2 = 64'd1; c_sub = 1'b1; c_cin = 1'b0; end
        default: begin
          c_op1 = {$urandom, $urandom}; c_op2 = {$urandom, $urandom};
          c_sub = 1'($urandom); c_cin = 1'($urandom);
        end
      endcase
      ref_add(64, c_op1, c_op2, c_sub, c_cin, es, eco, eov);
      c_vin = 1'b1;
      step();
      c_vin = 1'b0;
      repeat (7) step();
      checks++;
      if ({c_vout, c_cout, c_ovf, c_zero, c_sum} !== {1'b1, eco, eov, (es == 64'd0), es}) begin
        errors++;
        $display("FAIL w64_%0d got v%b c%b o%b z%b %h want v1 c%b o%b z%b %h",
                 i, c_vout, c_cout, c_ovf, c_zero, c_sum, eco, eov, (es == 64'd0), es);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_inflight();
    test_w8();
    test_w64();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
